gpmc_bus_bridge: RTL
====================

# gpmc_bus_bridge

Converts the FPGA-side GPMC multiplexed address/data protocol into a simple request/acknowledge register-bus transaction stream for internal peripherals and memories. Sits directly downstream of the GPMC pad interface (`gpmc_sram`) and drives the internal bus consumed by the register file and SRAM controllers. Handles address latching, auto-increment bursts, wait-state insertion while the internal bus is slow, and timeout recovery.

## Interface
Parameters:
- ADDR_W, 16, width of the internal word address; latched from GPMC_AD_IN[ADDR_W-1:0].
- BURST_MAX, 16, maximum beats per chip-select assertion.
- TIMEOUT, 255, cycles allowed from BUS_REQ rise to BUS_ACK.

Ports:
- GPMC_CLK  in  1  sole clock; all logic is rising-edge.
- GPMC_RST_N  in  1  reset, asynchronous assert, active-low.
- GPMC_AD_IN  in  16  multiplexed address/write data.
- GPMC_DATA_OUT  out  16  registered read data.
- GPMC_CS, GPMC_ADV, GPMC_OE, GPMC_WE  in  1 each  active-low strobes.
- GPMC_BE0, GPMC_BE1  in  1 each  active-low byte enables (low/high byte).
- GPMC_WAIT  out  1  high = host must stall.
- BUS_REQ  out  1  request valid.
- BUS_WE  out  1  1 = write, 0 = read.
- BUS_ADDR  out  ADDR_W  word address.
- BUS_WDATA  out  16  write data.
- BUS_BE  out  2  active-high byte enables {hi, lo}.
- BUS_ACK  in  1  completes a request on the edge where REQ and ACK are both high.
- BUS_RDATA  in  16  read data, valid with BUS_ACK.
- ERR_TIMEOUT  out  1  sticky; cleared only by reset.

## Operation
- Reset: all outputs 0; state IDLE; address and beat counter 0.
- IDLE: CS low and ADV low sampled -> latch address and clear beat counter -> ADDR. Otherwise remain.
- ADDR: wait for ADV high.
  - WE low -> WR.
  - Else OE low -> RD_REQ.
  - WE and OE both low -> WR (write wins).
- WR: sample AD_IN and BE = ~{BE1,BE0}; assert REQ=1, WE=1, WAIT=1 until ACK.
  - On ACK: drop REQ, address+1, beat+1, WAIT=0.
  - If beat == BURST_MAX -> DONE.
  - Otherwise capture the next beat while WE stays low.
- RD_REQ: REQ=1, WE=0, BE=2'b11, WAIT=1.
  - On ACK: DATA_OUT <= BUS_RDATA -> RD_DATA.
- RD_DATA: one cycle with WAIT=0 and data valid; address+1, beat+1.
  - OE still low and beat < BURST_MAX -> RD_REQ.
  - Beat == BURST_MAX -> DONE.
  - OE high -> DONE.
- DONE: WAIT=0; CS high -> IDLE.
- CS high in any state:
  - No REQ outstanding -> IDLE next cycle.
  - REQ outstanding -> DRAIN: keep REQ until ACK or timeout, discard the result, then IDLE.
- Timeout: a counter runs while REQ is high. At count == TIMEOUT:
  - drop REQ, set ERR_TIMEOUT, WAIT=0;
  - for a read, DATA_OUT = 16'hDEAD;
  - next state DONE (DRAIN -> IDLE).
- Address increments modulo 2^ADDR_W; 0xFFFF + 1 = 0x0000 at ADDR_W=16.
- BUS_ADDR, BUS_WDATA and BUS_BE hold stable while REQ is high.

## Timing
- Address latch: edge where CS=0 and ADV=0 are sampled.
- BUS_REQ rises the cycle after WE/OE is sampled low in ADDR or WR/RD_REQ (registered output).
- Zero-wait slave (ACK in the first REQ cycle): write beat every 2 cycles. Read data is on DATA_OUT with WAIT=0 exactly one cycle after the ACK edge.
- GPMC_WAIT is registered. It rises together with REQ and falls the cycle after ACK.
- ACK while REQ is low is ignored.
- Async reset mid-transaction: REQ drops immediately; no bus handshake is completed.

## Structure
- Shared package gpmc_pkg:
  - state enum (IDLE, ADDR, WR, RD_REQ, RD_DATA, DONE, DRAIN);
  - READ_ERR_DATA = 16'hDEAD;
  - default TIMEOUT and BURST_MAX constants;
  - function mapping active-low BE0/BE1 to an active-high 2-bit enable.
- One sub-module, gpmc_req_timer: loadable cycle counter with clear-on-ACK and a terminal-count pulse.

## Test plan
- Single write: ADV/CS low with AD=0x0040, then WE low with AD=0xBEEF, BE1=1, BE0=0 -> one REQ with ADDR=0x0040, WDATA=0xBEEF, BE=2'b01; ACK after 3 cycles -> WAIT high for exactly those cycles.
- Read burst of 4 at 0x0010, zero-wait slave returning addr+0x1000 -> DATA_OUT sequence 0x1010, 0x1011, 0x1012, 0x1013, each valid one cycle with WAIT=0.
- Wrap: address 0xFFFF, 2-beat write -> BUS_ADDR 0xFFFF then 0x0000.
- Burst limit: hold WE low for 20 beats -> exactly BURST_MAX=16 requests, then DONE until CS high.
- Timeout: read with ACK never asserted -> REQ drops after 255 cycles, ERR_TIMEOUT=1 and stays 1, DATA_OUT=0xDEAD, WAIT=0.
- Abort: CS high while a read REQ is pending, ACK 5 cycles later -> REQ held until ACK, DATA_OUT unchanged, IDLE next cycle; assert GPMC_RST_N low mid-write -> all outputs 0 immediately.

Source files
------------

// File: rtl/gpmc_pkg.sv
// rtl/gpmc_pkg.sv - shared types and constants for the GPMC bus bridge
package gpmc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR,
    RD_REQ,
    RD_DATA,
    DONE,
    DRAIN
  } gpmc_state_e;

  localparam logic [15:0] READ_ERR_DATA     = 16'hDEAD;
  localparam int          DEFAULT_TIMEOUT   = 255;
  localparam int          DEFAULT_BURST_MAX = 16;

  // GPMC byte enables are active-low; the internal bus wants {hi, lo} active-high
  function automatic logic [1:0] be_from_n(input logic be1_n, input logic be0_n);
    return {~be1_n, ~be0_n};
  endfunction

endpackage

// File: rtl/gpmc_req_timer.sv
// rtl/gpmc_req_timer.sv - request watchdog counter with terminal-count pulse
module gpmc_req_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          load_i,
  input  logic [$clog2(TIMEOUT+1)-1:0]  load_val_i,
  input  logic                          clr_i,
  output logic                          tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count request cycles; an ACK or an idle request resets the count
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (clr_i || !en_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the last permitted request cycle so REQ is high exactly TIMEOUT cycles
  assign tc_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/gpmc_bus_bridge.sv
// rtl/gpmc_bus_bridge.sv - GPMC multiplexed host port to request/ack register bus
module gpmc_bus_bridge
  import gpmc_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BURST_MAX = DEFAULT_BURST_MAX,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic              GPMC_CLK,
  input  logic              GPMC_RST_N,
  input  logic [15:0]       GPMC_AD_IN,
  output logic [15:0]       GPMC_DATA_OUT,
  input  logic              GPMC_CS,
  input  logic              GPMC_ADV,
  input  logic              GPMC_OE,
  input  logic              GPMC_WE,
  input  logic              GPMC_BE0,
  input  logic              GPMC_BE1,
  output logic              GPMC_WAIT,
  output logic              BUS_REQ,
  output logic              BUS_WE,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [15:0]       BUS_WDATA,
  output logic [1:0]        BUS_BE,
  input  logic              BUS_ACK,
  input  logic [15:0]       BUS_RDATA,
  output logic              ERR_TIMEOUT
);

  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam int TCW    = $clog2(TIMEOUT + 1);

  gpmc_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        be_q, be_d;
  logic              wait_q, wait_d;
  logic [15:0]       dout_q, dout_d;
  logic              err_q, err_d;

  logic              ack;
  logic              tmo;
  logic [BEAT_W-1:0] beat_nxt;
  logic              last_beat;

  // ACK only counts while a request is actually presented
  assign ack       = BUS_ACK & req_q;
  assign beat_nxt  = beat_q + BEAT_W'(1);
  assign last_beat = (beat_nxt == BEAT_W'(BURST_MAX));

  gpmc_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_req_timer (
    .clk_i      (GPMC_CLK),
    .rst_ni     (GPMC_RST_N),
    .en_i       (req_q),
    .load_i     (req_d & ~req_q),
    .load_val_i (TCW'(0)),
    .clr_i      (ack),
    .tc_o       (tmo)
  );

  // Next-state and registered-output decode for the host/bus handshake
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    req_d   = req_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wait_d  = wait_q;
    dout_d  = dout_q;
    err_d   = err_q;

    if (GPMC_CS && state_q != IDLE && state_q != DRAIN) begin
      // Host abandoned the cycle: finish any bus request silently, then idle
      wait_d = 1'b0;
      if (req_q && !ack && !tmo) begin
        state_d = DRAIN;
      end else begin
        req_d   = 1'b0;
        state_d = IDLE;
        if (tmo) err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!GPMC_CS && !GPMC_ADV) begin
            addr_d  = GPMC_AD_IN[ADDR_W-1:0];
            beat_d  = '0;
            state_d = ADDR;
          end
        end
        ADDR: begin
          if (GPMC_ADV) begin
            if (!GPMC_WE) begin
              req_d   = 1'b1;
              we_d    = 1'b1;
              wait_d  = 1'b1;
              wdata_d = GPMC_AD_IN;
              be_d    = be_from_n(GPMC_BE1, GPMC_BE0);
              state_d = WR;
            end else if (!GPMC_OE) begin
              req_d   = 1'b1;
              we_d    = 1'b0;
              wait_d  = 1'b1;
              be_d    = 2'b11;
              state_d = RD_REQ;
            end
          end
        end
        WR: begin
          if (req_q) begin
            if (ack) begin
              req_d  = 1'b0;
              wait_d = 1'b0;
              addr_d = addr_q + ADDR_W'(1);
              beat_d = beat_nxt;
              if (last_beat) state_d = DONE;
            end else if (tmo) begin
              req_d   = 1'b0;
              wait_d  = 1'b0;
              err_d   = 1'b1;
              state_d = DONE;
            end
          end else if (!GPMC_WE) begin
            req_d   = 1'b1;
            wait_d  = 1'b1;
            wdata_d = GPMC_AD_IN;
            be_d    = be_from_n(GPMC_BE1, GPMC_BE0);
          end
        end
        RD_REQ: begin
          if (ack) begin
            req_d   = 1'b0;
            wait_d  = 1'b0;
            dout_d  = BUS_RDATA;
            state_d = RD_DATA;
          end else if (tmo) begin
            req_d   = 1'b0;
            wait_d  = 1'b0;
            err_d   = 1'b1;
            dout_d  = READ_ERR_DATA;
            state_d = DONE;
          end
        end
        RD_DATA: begin
          addr_d = addr_q + ADDR_W'(1);
          beat_d = beat_nxt;
          if (!last_beat && !GPMC_OE) begin
            req_d   = 1'b1;
            wait_d  = 1'b1;
            state_d = RD_REQ;
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          wait_d = 1'b0;
        end
        DRAIN: begin
          if (ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else if (tmo) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset drops any request immediately
  always_ff @(posedge GPMC_CLK or negedge GPMC_RST_N) begin
    if (!GPMC_RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      wait_q  <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wait_q  <= wait_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign GPMC_DATA_OUT = dout_q;
  assign GPMC_WAIT     = wait_q;
  assign BUS_REQ       = req_q;
  assign BUS_WE        = we_q;
  assign BUS_ADDR      = addr_q;
  assign BUS_WDATA     = wdata_q;
  assign BUS_BE        = be_q;
  assign ERR_TIMEOUT   = err_q;

endmodule
